alu_arb_ctrl: RTL

- Controller that shares one 8-bit ALU datapath between NREQ requesters.
- Arbitrates requests round-robin and drives the ALU operand muxes, input-select and output-select controls.
- Waits the ALU latency, then returns the result and overflow error to the granted requester.
- Runs the off/ready/run/run_error state machine that sequences the ALU; sits between bus-side requesters and the ALU datapath.

---
 rtl/alu_arb_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arb_ctrl.sv
// alu_arb_ctrl: shares one W-bit ALU datapath among NREQ requesters.
// Grants one request at a time (round-robin), drives the ALU operand and
// selector controls, waits LAT cycles for the result and returns it with an
// error flag to the granted requester.
// Optional macro ALU_ARB_FIXED_PRIO_EN: fixed priority (lowest valid index
// wins) instead of round-robin; the round-robin pointer is then absent.
module alu_arb_ctrl #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 8,
    parameter int unsigned LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              on,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [W-1:0]      alu_num1,
    output logic [W-1:0]      alu_num2,
    output logic [2:0]        alu_in_selector,
    output logic [6:0]        alu_out_selector,
    input  logic [W-1:0]      alu_result,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_error,
    output logic [1:0]        state
);

    localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [2:0] IN_RESET   = 3'b001;
    localparam logic [2:0] IN_LOAD    = 3'b010;
    localparam logic [2:0] IN_PERSIST = 3'b100;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        S_OFF       = 2'b00,
        S_READY     = 2'b01,
        S_RUN       = 2'b10,
        S_RUN_ERROR = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   num1_q, num1_d;
    logic [W-1:0]   num2_q, num2_d;
    logic [6:0]     out_sel_q, out_sel_d;
    logic [2:0]     id_q, id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [2:0]     rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_error_q, rsp_error_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [2:0]     ptr_q, ptr_d;
`endif

    logic           gnt_found;
    logic [2:0]     gnt_idx;
    logic [2:0]     gnt_op;
    int unsigned    idx;

    // Grant search over valid requests (round-robin from pointer+1, or lowest index)
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (32'(ptr_q) + 1 + i) % NREQ;
`endif
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = 3'(idx);
            end
        end
        gnt_op = req_op[3*gnt_idx +: 3];
    end

    // Next-state, grant, operand latch and response logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        out_sel_d   = out_sel_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        req_ready   = '0;
        case (state_q)
            S_OFF: begin
                if (on) state_d = S_READY;
            end
            S_READY: begin
                if (!on) begin
                    state_d = S_OFF;
                end else if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    ptr_d = gnt_idx;
`endif
                    if (gnt_op == OP_ILLEGAL) begin
                        // Answered straight away; the ALU is never issued
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_id_d    = gnt_idx;
                        out_sel_d   = '0;
                    end else begin
                        num1_d    = req_a[W*gnt_idx +: W];
                        num2_d    = req_b[W*gnt_idx +: W];
                        out_sel_d = 7'd1 << gnt_op;
                        id_d      = gnt_idx;
                        cnt_d     = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // cnt 0 is the load cycle; the result is valid LAT cycles later
                if (cnt_q == CW'(LAT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_result;
                    rsp_error_d = alu_overflow;
                    rsp_id_d    = id_q;
                    state_d     = alu_overflow ? S_RUN_ERROR : S_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN_ERROR: begin
                state_d = S_READY;
            end
            default: state_d = S_OFF;
        endcase
    end

    // ALU input-select control derived from the current state
    always_comb begin
        alu_in_selector = IN_PERSIST;
        case (state_q)
            S_OFF, S_RUN_ERROR: alu_in_selector = IN_RESET;
            S_RUN:              alu_in_selector = (cnt_q == '0) ? IN_LOAD : IN_PERSIST;
            default:            alu_in_selector = IN_PERSIST;
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            out_sel_q   <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q       <= 3'(NREQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            out_sel_q   <= out_sel_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign alu_num1         = num1_q;
    assign alu_num2         = num2_q;
    assign alu_out_selector = out_sel_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_error        = rsp_error_q;
    assign state            = state_q;

endmodule
